vga_frame_scheduler: RTL and testbench

- Owns VGA 640x480@60 timing.
- Divides the system clock to a pixel tick, and runs the horizontal (0..799) and vertical (0..524) counters.
- Decodes hsync, vsync and video_on.
- Schedules Game-of-Life generation updates: after every FRAMES_PER_GEN frames, it issues a req/ack handshake to the cell-update engine during vertical blanking, so that cell RAM is never rewritten mid-scan.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_sync_counter.sv | 56 +++++
 rtl/vga_frame_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_vga_frame_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing defaults, counter width and scheduler states.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FP      = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BP      = 48;
  localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP
                               + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FP      = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BP      = 33;
  localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP
                               + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic {
    S_WAIT = 1'b0,
    S_REQ  = 1'b1
  } sched_state_e;

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel-clock divider plus horizontal/vertical raster counters.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int V_TOTAL = VGA_V_TOTAL
) (
  input  logic             i_clk,
  input  logic             i_reset,
  output logic             o_pixel_tick,
  output logic             o_line_wrap,
  output logic             o_frame_tick,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_h;
  logic [CNT_W-1:0] r_v;
  logic             w_tick;
  logic             w_h_wrap;
  logic             w_v_last;

  assign w_tick   = (r_div == DIV_LAST);
  assign w_h_wrap = w_tick && (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_h <= w_h_wrap ? '0 : r_h + 1'b1;
      end
      if (w_h_wrap) begin
        r_v <= w_v_last ? '0 : r_v + 1'b1;
      end
    end
  end

  assign o_pixel_tick = w_tick;
  assign o_line_wrap  = w_h_wrap;
  assign o_frame_tick = w_h_wrap && w_v_last;
  assign o_h_cnt      = r_h;
  assign o_v_cnt      = r_v;

endmodule

// File: rtl/vga_frame_scheduler.sv
// VGA timing, sync decode and vblank-aligned generation scheduler.
// Define GEN_PAUSE_EN to add pause/step control of generation requests.
module vga_frame_scheduler
  import vga_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int H_VISIBLE      = VGA_H_VISIBLE,
  parameter int H_FP           = VGA_H_FP,
  parameter int H_SYNC         = VGA_H_SYNC,
  parameter int H_BP           = VGA_H_BP,
  parameter int V_VISIBLE      = VGA_V_VISIBLE,
  parameter int V_FP           = VGA_V_FP,
  parameter int V_SYNC         = VGA_V_SYNC,
  parameter int V_BP           = VGA_V_BP,
  parameter int FRAMES_PER_GEN = 30
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_gen_ack,
`ifdef GEN_PAUSE_EN
  input  logic             i_pause,
  input  logic             i_step,
`endif
  output logic             o_pixel_tick,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_video_on,
  output logic [CNT_W-1:0] o_x,
  output logic [CNT_W-1:0] o_y,
  output logic             o_frame_tick,
  output logic             o_gen_req,
  output logic             o_gen_overrun
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int FRM_W   = $clog2(FRAMES_PER_GEN + 1);

  localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_B  = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_E  = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_B  = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_E  = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] VB_PRE = CNT_W'(V_VISIBLE - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAMES_PER_GEN - 1);

  logic             w_tick;
  logic             w_line_wrap;
  logic             w_frame_tick;
  logic [CNT_W-1:0] w_h;
  logic [CNT_W-1:0] w_v;
  logic             w_vblank;

  vga_sync_counter #(
    .CLK_DIV (CLK_DIV),
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_cnt (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .o_pixel_tick (w_tick),
    .o_line_wrap  (w_line_wrap),
    .o_frame_tick (w_frame_tick),
    .o_h_cnt      (w_h),
    .o_v_cnt      (w_v)
  );

  // vblank begins on the line wrap that takes v_cnt to V_VISIBLE
  assign w_vblank = w_line_wrap && (w_v == VB_PRE);

  logic [CNT_W-1:0] r_x;
  logic [CNT_W-1:0] r_y;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b0;
    end else begin
      r_x        <= w_h;
      r_y        <= w_v;
      r_hsync    <= !((w_h >= HS_B) && (w_h <= HS_E));
      r_vsync    <= !((w_v >= VS_B) && (w_v <= VS_E));
      r_video_on <= (w_h < H_VIS) && (w_v < V_VIS);
    end
  end

  sched_state_e     r_state;
  sched_state_e     w_state_nxt;
  logic [FRM_W-1:0] r_frm;
  logic [FRM_W-1:0] w_frm_nxt;
  logic             r_ovr;
  logic             w_ovr_nxt;
  logic             w_hold;
  logic             w_armed;

`ifdef GEN_PAUSE_EN
  logic r_arm;
  logic w_arm_nxt;

  assign w_hold  = i_pause;
  assign w_armed = r_arm;

  always_comb begin
    w_arm_nxt = r_arm;
    if (r_state == S_WAIT) begin
      if (w_vblank && r_arm) begin
        w_arm_nxt = 1'b0;
      end else if (i_pause && i_step) begin
        w_arm_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_arm <= 1'b0;
    end else begin
      r_arm <= w_arm_nxt;
    end
  end
`else
  assign w_hold  = 1'b0;
  assign w_armed = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_frm_nxt   = r_frm;
    w_ovr_nxt   = r_ovr;
    unique case (r_state)
      S_WAIT: begin
        if (w_vblank) begin
          if (w_armed) begin
            w_state_nxt = S_REQ;
          end else if (!w_hold) begin
            if (r_frm == FRM_LAST) begin
              w_frm_nxt   = '0;
              w_state_nxt = S_REQ;
            end else begin
              w_frm_nxt = r_frm + 1'b1;
            end
          end
        end
      end
      S_REQ: begin
        // ack beats a coincident frame_tick
        if (i_gen_ack) begin
          w_state_nxt = S_WAIT;
        end else if (w_frame_tick) begin
          w_ovr_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_WAIT;
      r_frm   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_frm   <= w_frm_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  assign o_pixel_tick  = w_tick;
  assign o_frame_tick  = w_frame_tick;
  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_video_on    = r_video_on;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_gen_req     = (r_state == S_REQ);
  assign o_gen_overrun = r_ovr;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Bench: small-raster DUT vs arithmetic raster model, plus a full-size DUT.
module tb_vga_frame_scheduler;

  localparam int D   = 2;
  localparam int HV  = 16;
  localparam int HF  = 2;
  localparam int HS  = 3;
  localparam int HB  = 3;
  localparam int VV  = 8;
  localparam int VF  = 2;
  localparam int VS  = 2;
  localparam int VB  = 3;
  localparam int FPG = 3;
  localparam int HT  = HV + HF + HS + HB;
  localparam int FRAME = D * HT * (VV + VF + VS + VB);

  typedef struct packed {
    logic       tick;
    logic       ft;
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] x;
    logic [9:0] y;
    logic       req;
    logic       ovr;
  } out_t;

  typedef struct {
    int   n;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic gen_ack = 1'b0;
  logic pause = 1'b0;
  logic step = 1'b0;

  logic       s_tick, s_hs, s_vs, s_von, s_ft, s_req, s_ovr;
  logic [9:0] s_x, s_y;
  logic       f_tick, f_hs, f_vs, f_von, f_ft, f_req, f_ovr;
  logic [9:0] f_x, f_y;

  always #5 clk = ~clk;

  vga_frame_scheduler #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FRAMES_PER_GEN(FPG)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_gen_ack(gen_ack),
`ifdef GEN_PAUSE_EN
    .i_pause(pause), .i_step(step),
`endif
    .o_pixel_tick(s_tick), .o_hsync(s_hs), .o_vsync(s_vs),
    .o_video_on(s_von), .o_x(s_x), .o_y(s_y),
    .o_frame_tick(s_ft), .o_gen_req(s_req), .o_gen_overrun(s_ovr)
  );

  vga_frame_scheduler dut_full (
    .i_clk(clk), .i_reset(reset), .i_gen_ack(1'b0),
`ifdef GEN_PAUSE_EN
    .i_pause(1'b0), .i_step(1'b0),
`endif
    .o_pixel_tick(f_tick), .o_hsync(f_hs), .o_vsync(f_vs),
    .o_video_on(f_von), .o_x(f_x), .o_y(f_y),
    .o_frame_tick(f_ft), .o_gen_req(f_req), .o_gen_overrun(f_ovr)
  );

  int n = 0;
  int vecs = 0;
  int fails = 0;
  int rises = 0;
  bit prev_req = 1'b0;
  bit m_req = 1'b0;
  bit m_ovr = 1'b0;
  bit m_arm = 1'b0;
  int m_frames = 0;

  // Raster state after n clock edges since reset release, from plain arithmetic.
  function automatic out_t timing(input int nn, input int d,
      input int hv, input int hf, input int hs, input int hb,
      input int vv, input int vf, input int vs, input int vb);
    int ht, tot, p, q, xx, yy;
    out_t r;
    ht = hv + hf + hs + hb;
    tot = ht * (vv + vf + vs + vb);
    p = (nn / d) % tot;
    r = '0;
    r.tick = ((nn % d) == d - 1);
    r.ft = r.tick && (p == tot - 1);
    if (nn == 0) begin
      r.hs = 1'b1;
      r.vs = 1'b1;
    end else begin
      q = ((nn - 1) / d) % tot;
      xx = q % ht;
      yy = q / ht;
      r.x = 10'(xx);
      r.y = 10'(yy);
      r.hs = !((xx >= hv + hf) && (xx < hv + hf + hs));
      r.vs = !((yy >= vv + vf) && (yy < vv + vf + vs));
      r.von = (xx < hv) && (yy < vv);
    end
    return r;
  endfunction

  function automatic out_t small_t(input int nn);
    return timing(nn, D, HV, HF, HS, HB, VV, VF, VS, VB);
  endfunction

  function automatic bit is_vblank(input int nn);
    return ((nn % D) == D - 1) && (((nn / D) % (FRAME / D)) == VV * HT - 1);
  endfunction

  function automatic out_t mk(input int tk, input int ft, input int hs,
      input int vs, input int von, input int x, input int y);
    out_t r;
    r = '0;
    r.tick = tk[0];
    r.ft = ft[0];
    r.hs = hs[0];
    r.vs = vs[0];
    r.von = von[0];
    r.x = 10'(x);
    r.y = 10'(y);
    return r;
  endfunction

  function automatic out_t got_small();
    out_t r;
    r = {s_tick, s_ft, s_hs, s_vs, s_von, s_x, s_y, s_req, s_ovr};
    return r;
  endfunction

  task automatic check_all();
    out_t es, ef, gs, gf;
    es = small_t(n);
    es.req = m_req;
    es.ovr = m_ovr;
    ef = timing(n, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    gs = got_small();
    gf = {f_tick, f_ft, f_hs, f_vs, f_von, f_x, f_y, f_req, f_ovr};
    vecs++;
    if (gs !== es || gf !== ef) begin
      fails++;
      $display("FAIL cycle n=%0d small got=%h exp=%h full got=%h exp=%h",
               n, gs, es, gf, ef);
    end
    if (s_req && !prev_req) rises++;
    prev_req = s_req;
  endtask

  task automatic chk(input string name, input logic got, input logic exp);
    vecs++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    vecs++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic model_edge(input bit ack, input bit pz, input bit st);
    bit vb, ft;
    vb = is_vblank(n);
    ft = small_t(n).ft;
    if (!m_req) begin
      if (vb && m_arm) begin
        m_req = 1'b1;
        m_arm = 1'b0;
      end else begin
        if (pz && st) m_arm = 1'b1;
        if (vb && !pz) begin
          m_frames++;
          if (m_frames == FPG) begin
            m_frames = 0;
            m_req = 1'b1;
          end
        end
      end
    end else if (ack) begin
      m_req = 1'b0;
    end else if (ft) begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic step_cyc(input bit ack, input bit pz, input bit st);
    gen_ack = ack;
    pause = pz;
    step = st;
`ifdef GEN_PAUSE_EN
    model_edge(ack, pz, st);
`else
    model_edge(ack, 1'b0, 1'b0);
`endif
    n++;
    @(negedge clk);
    gen_ack = 1'b0;
    step = 1'b0;
    check_all();
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    gen_ack = 1'b0;
    pause = 1'b0;
    step = 1'b0;
    m_req = 1'b0;
    m_ovr = 1'b0;
    m_arm = 1'b0;
    m_frames = 0;
    n = 0;
    repeat (cyc) begin
      @(negedge clk);
      check_all();
    end
    reset = 1'b0;
    rises = 0;
    prev_req = 1'b0;
  endtask

  // mode 0: ack 5 clk after req, 1: never, 2: on frame_tick, 3: random
  task automatic run(input int cycles, input int mode, input bit pz);
    int wcnt;
    bit ack;
    wcnt = 0;
    for (int i = 0; i < cycles; i++) begin
      ack = 1'b0;
      case (mode)
        0: begin
          if (m_req) begin
            ack = (wcnt == 4);
            wcnt++;
          end else begin
            wcnt = 0;
          end
        end
        2: ack = m_req && small_t(n).ft;
        3: ack = m_req ? ($urandom_range(0, 7) == 0)
                       : ($urandom_range(0, 15) == 0);
        default: ack = 1'b0;
      endcase
      step_cyc(ack, pz, 1'b0);
    end
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{0,   mk(0, 0, 1, 1, 0, 0, 0)};
    tbl[1]  = '{1,   mk(1, 0, 1, 1, 1, 0, 0)};
    tbl[2]  = '{2,   mk(0, 0, 1, 1, 1, 0, 0)};
    tbl[3]  = '{3,   mk(1, 0, 1, 1, 1, 1, 0)};
    tbl[4]  = '{33,  mk(1, 0, 1, 1, 0, 16, 0)};
    tbl[5]  = '{37,  mk(1, 0, 0, 1, 0, 18, 0)};
    tbl[6]  = '{41,  mk(1, 0, 0, 1, 0, 20, 0)};
    tbl[7]  = '{43,  mk(1, 0, 1, 1, 0, 21, 0)};
    tbl[8]  = '{47,  mk(1, 0, 1, 1, 0, 23, 0)};
    tbl[9]  = '{49,  mk(1, 0, 1, 1, 1, 0, 1)};
    tbl[10] = '{385, mk(1, 0, 1, 1, 0, 0, 8)};
    tbl[11] = '{481, mk(1, 0, 1, 0, 0, 0, 10)};
    tbl[12] = '{577, mk(1, 0, 1, 1, 0, 0, 12)};
    tbl[13] = '{719, mk(1, 1, 1, 1, 0, 23, 14)};
    tbl[14] = '{720, mk(0, 0, 1, 1, 0, 23, 14)};
    tbl[15] = '{721, mk(1, 0, 1, 1, 1, 0, 0)};

    @(negedge clk);
    do_reset(3);
    foreach (tbl[i]) begin
      while (n < tbl[i].n) step_cyc(1'b0, 1'b0, 1'b0);
      vecs++;
      if (got_small() !== tbl[i].exp) begin
        fails++;
        $display("FAIL table[%0d] n=%0d got=%h exp=%h",
                 i, n, got_small(), tbl[i].exp);
      end
    end

    do_reset(2);
    run(6600, 0, 1'b0);
    chk_int("req_rises_frames_3_6_9", rises, 3);
    chk("no_overrun_with_ack", s_ovr, 1'b0);

    do_reset(2);
    run(2300, 1, 1'b0);
    chk("overrun_set", s_ovr, 1'b1);
    chk("req_held", s_req, 1'b1);
    run(800, 1, 1'b0);
    chk("overrun_sticky", s_ovr, 1'b1);
    do_reset(1);
    chk("reset_clears_req", s_req, 1'b0);
    chk("reset_clears_ovr", s_ovr, 1'b0);

    do_reset(2);
    run(2300, 2, 1'b0);
    chk("ack_on_frame_tick_no_ovr", s_ovr, 1'b0);
    chk("ack_on_frame_tick_wait", s_req, 1'b0);

    do_reset(2);
    run(1900, 1, 1'b0);
    chk("req_before_reset", s_req, 1'b1);
    do_reset(1);
    chk("req_dropped_on_reset", s_req, 1'b0);
    chk("hsync_reset", s_hs, 1'b1);

    do_reset(2);
    run(15000, 3, 1'b0);

`ifdef GEN_PAUSE_EN
    do_reset(2);
    run(10 * FRAME, 0, 1'b1);
    chk_int("paused_no_req", rises, 0);
    step_cyc(1'b0, 1'b1, 1'b1);
    run(FRAME, 0, 1'b1);
    chk_int("step_one_req", rises, 1);
    run(4 * FRAME, 0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
